// File: rtl/wb_axi_pkg.sv
// Shared types and defaults for the Wishbone to AXI4-Lite / AXI-Stream bridge family.
package wb_axi_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WR,
    ST_B,
    ST_RD_A,
    ST_RD_D,
    ST_SS,
    ST_SM,
    ST_ACK,
    ST_ERR
  } state_t;

  localparam int          TMO_W         = 8;
  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEAD_BEEF;
  localparam logic [11:0] SS_OFF_DFLT   = 12'h040;
  localparam logic [11:0] SM_OFF_DFLT   = 12'h044;
  localparam logic [11:0] LEN_OFF_DFLT  = 12'h010;

  // States in which a peer handshake is outstanding and the hang timer runs.
  function automatic logic is_busy(input state_t s);
    return s inside {ST_WR, ST_B, ST_RD_A, ST_RD_D, ST_SS, ST_SM};
  endfunction

endpackage

// File: rtl/wb_axi_bridge_v2_if.sv
// Bus bundle for the bridge: Wishbone slave port, AXI4-Lite master and AXI-Stream master/slave.
interface wb_axi_bridge_v2_if #(
  parameter int ADDR_W = 12
);
  logic              wbs_stb_i;
  logic              wbs_cyc_i;
  logic              wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i;
  logic [31:0]       wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              bvalid;
  logic              bready;
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [31:0]       rdata;
  logic              ss_tvalid;
  logic              ss_tready;
  logic [31:0]       ss_tdata;
  logic              ss_tlast;
  logic              sm_tvalid;
  logic              sm_tready;
  logic [31:0]       sm_tdata;
  logic              sm_tlast;

  // "slave" is the bridge (Wishbone slave side); "master" is the surrounding environment.
  modport slave (
    input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    output wbs_ack_o, wbs_dat_o,
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata,
    output ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    input  ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );

  modport master (
    output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
    input  wbs_ack_o, wbs_dat_o,
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, arready, rvalid, rdata,
    input  ss_tvalid, ss_tdata, ss_tlast, sm_tready,
    output ss_tready, sm_tvalid, sm_tdata, sm_tlast
  );
endinterface

// File: rtl/wb_axi_len_ctr.sv
// Stream length counter: loaded by a register write, decremented per beat, flags the last beat.
module wb_axi_len_ctr #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  input  logic              dec,
  output logic              last
);

  logic [DATA_W-1:0] len_cnt;

  // Saturates at zero so an unprogrammed length never produces tlast.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_cnt <= '0;
    end else if (load) begin
      len_cnt <= load_val;
    end else if (dec && (len_cnt != '0)) begin
      len_cnt <= len_cnt - DATA_W'(1);
    end
  end

  assign last = (len_cnt == DATA_W'(1));

endmodule

// File: rtl/wb_axi_bridge_v2.sv
// Registered Wishbone-slave bridge to AXI4-Lite master and AXI-Stream master/slave with hang timeout.
module wb_axi_bridge_v2
  import wb_axi_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 12,
  parameter logic [ADDR_W-1:0] SS_OFF  = ADDR_W'(SS_OFF_DFLT),
  parameter logic [ADDR_W-1:0] SM_OFF  = ADDR_W'(SM_OFF_DFLT),
  parameter logic [ADDR_W-1:0] LEN_OFF = ADDR_W'(LEN_OFF_DFLT),
  parameter int          TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = ERR_DATA_DFLT
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_i,
  wb_axi_bridge_v2_if.slave   bus,
  output logic                timeout_o
);

  state_t            state_q, state_nx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              aw_done, w_done;
  logic [ADDR_W-1:0] off, addr_q;
  logic [31:0]       data_q, dat_q, dat_d;
  logic [3:0]        sel_q;
  logic              req, in_win, tmo_hit, tmo_set, len_load, len_last;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, ss_hs, sm_hs;
  logic              awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic              ss_tvalid_q, ss_tlast_q, sm_tready_q, ack_q;
  logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic              ss_tvalid_d, ss_tlast_d, sm_tready_d, ack_d;

  assign off     = bus.wbs_adr_i[ADDR_W-1:0];
  assign in_win  = (bus.wbs_adr_i[31:ADDR_W] == BASE_ADDR[31:ADDR_W]);
  assign req     = bus.wbs_cyc_i && bus.wbs_stb_i && in_win && !ack_q;
  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT));

  assign aw_hs = awvalid_q   && bus.awready;
  assign w_hs  = wvalid_q    && bus.wready;
  assign b_hs  = bready_q    && bus.bvalid;
  assign ar_hs = arvalid_q   && bus.arready;
  assign r_hs  = rready_q    && bus.rvalid;
  assign ss_hs = ss_tvalid_q && bus.ss_tready;
  assign sm_hs = sm_tready_q && bus.sm_tvalid;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state_q <= ST_IDLE;
    else          state_q <= state_nx;
  end

  // A handshake landing on the timeout cycle wins: the peer has already consumed it.
  always_comb begin
    state_nx = state_q;
    unique case (state_q)
      ST_IDLE: if (req) begin
        if (off == SS_OFF)      state_nx = bus.wbs_we_i ? ST_SS : ST_ERR;
        else if (off == SM_OFF) state_nx = bus.wbs_we_i ? ST_ERR : ST_SM;
        else                    state_nx = bus.wbs_we_i ? ST_WR : ST_RD_A;
      end
      ST_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = ST_B;
               else if (tmo_hit)                           state_nx = ST_ERR;
      ST_B:    if (b_hs)  state_nx = ST_ACK; else if (tmo_hit) state_nx = ST_ERR;
      ST_RD_A: if (ar_hs) state_nx = ST_RD_D; else if (tmo_hit) state_nx = ST_ERR;
      ST_RD_D: if (r_hs)  state_nx = ST_ACK; else if (tmo_hit) state_nx = ST_ERR;
      ST_SS:   if (ss_hs) state_nx = ST_ACK; else if (tmo_hit) state_nx = ST_ERR;
      ST_SM:   if (sm_hs) state_nx = ST_ACK; else if (tmo_hit) state_nx = ST_ERR;
      ST_ACK:  state_nx = ST_IDLE;
      ST_ERR:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    awvalid_d   = (state_nx == ST_WR) && !(aw_done || aw_hs);
    wvalid_d    = (state_nx == ST_WR) && !(w_done || w_hs);
    bready_d    = (state_nx == ST_B);
    arvalid_d   = (state_nx == ST_RD_A);
    rready_d    = (state_nx == ST_RD_D);
    ss_tvalid_d = (state_nx == ST_SS);
    sm_tready_d = (state_nx == ST_SM);
    ss_tlast_d  = ss_tvalid_d && len_last;
    ack_d       = (state_nx inside {ST_ACK, ST_ERR}) && bus.wbs_cyc_i;
    tmo_set     = (state_nx == ST_ERR);
    dat_d       = dat_q;
    if (state_nx == ST_ERR) dat_d = ERR_DATA;
    else if (r_hs)          dat_d = bus.rdata;
    else if (sm_hs)         dat_d = bus.sm_tdata;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      ss_tvalid_q <= 1'b0;
      ss_tlast_q  <= 1'b0;
      sm_tready_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      timeout_o   <= 1'b0;
      tmo_cnt     <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
    end else begin
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      ss_tvalid_q <= ss_tvalid_d;
      ss_tlast_q  <= ss_tlast_d;
      sm_tready_q <= sm_tready_d;
      ack_q       <= ack_d;
      dat_q       <= dat_d;
      if (tmo_set) timeout_o <= 1'b1;
      if (state_q == ST_IDLE)   tmo_cnt <= '0;
      else if (is_busy(state_q)) tmo_cnt <= tmo_cnt + TMO_W'(1);
      aw_done <= (state_q == ST_IDLE) ? 1'b0 : (aw_done || aw_hs);
      w_done  <= (state_q == ST_IDLE) ? 1'b0 : (w_done || w_hs);
    end
  end

  // Request fields are frozen at IDLE exit so AXI address/data stay stable under valid.
  always_ff @(posedge wb_clk_i) begin
    if (state_q == ST_IDLE && req) begin
      addr_q <= off;
      data_q <= bus.wbs_dat_i;
      sel_q  <= bus.wbs_sel_i;
    end
  end

  assign len_load = b_hs && (addr_q == LEN_OFF);

  wb_axi_len_ctr #(.DATA_W(32)) u_len (
    .clk      (wb_clk_i),
    .rst      (wb_rst_i),
    .load     (len_load),
    .load_val (data_q),
    .dec      (ss_hs),
    .last     (len_last)
  );

  assign bus.awvalid   = awvalid_q;
  assign bus.awaddr    = addr_q;
  assign bus.wvalid    = wvalid_q;
  assign bus.wdata     = data_q;
  assign bus.wstrb     = sel_q;
  assign bus.bready    = bready_q;
  assign bus.arvalid   = arvalid_q;
  assign bus.araddr    = addr_q;
  assign bus.rready    = rready_q;
  assign bus.ss_tvalid = ss_tvalid_q;
  assign bus.ss_tdata  = data_q;
  assign bus.ss_tlast  = ss_tlast_q;
  assign bus.sm_tready = sm_tready_q;
  assign bus.wbs_ack_o = ack_q;
  assign bus.wbs_dat_o = dat_q;

  sm_tlast_with_tvalid: assert property (
    @(posedge wb_clk_i) disable iff (wb_rst_i) bus.sm_tlast |-> bus.sm_tvalid);

endmodule

// File: tb/tb_wb_axi_bridge_v2.sv
// Directed bench for wb_axi_bridge_v2: AXI-Lite writes/reads, stream beats, timeout, window, reset.
module tb_wb_axi_bridge_v2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timeout_o;

  always #5 clk = ~clk;

  wb_axi_bridge_v2_if #(.ADDR_W(12)) bus ();

  wb_axi_bridge_v2 #(.BASE_ADDR(32'h3000_0000), .ADDR_W(12)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .bus       (bus),
    .timeout_o (timeout_o)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {22'd0, bus.wbs_ack_o, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid,
            bus.rready, bus.ss_tvalid, bus.ss_tlast, bus.sm_tready, timeout_o};
  endfunction

  // Peer configuration written by the stimulus process.
  int          w_delay    = 0;
  int          r_delay    = 0;
  logic        ss_toggle  = 1'b0;
  logic [31:0] rdata_val  = '0;

  // AXI / AXIS peer: reacts just after each edge to the registered bridge outputs.
  int   w_wait = 0;
  int   r_wait = 0;
  logic tog    = 1'b0;
  initial begin
    bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.arready = 0;
    bus.rvalid = 0; bus.rdata = '0; bus.ss_tready = 0;
    bus.sm_tvalid = 0; bus.sm_tdata = '0; bus.sm_tlast = 0;
    forever begin
      @(posedge clk); #2;
      bus.awready = bus.awvalid;
      if (bus.wvalid) begin bus.wready = (w_wait >= w_delay); w_wait++; end
      else begin bus.wready = 1'b0; w_wait = 0; end
      bus.bvalid  = bus.bready;
      bus.arready = bus.arvalid;
      if (bus.rready) begin bus.rvalid = (r_wait >= r_delay); r_wait++; end
      else begin bus.rvalid = 1'b0; r_wait = 0; end
      bus.rdata = rdata_val;
      tog = !tog;
      bus.ss_tready = bus.ss_tvalid && (ss_toggle ? tog : 1'b1);
    end
  end

  // Monitor: handshake counters, captured fields and stream beats.
  int          cyc_no = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, ack_cnt = 0, act_cnt = 0;
  int          aw_cyc = 0, w_cyc = 0;
  logic [11:0] aw_addr_seen = 12'hFFF, ar_addr_seen = 12'hFFF;
  logic [31:0] w_data_seen = '1;
  logic [31:0] beat_data[$];
  logic        beat_last[$];
  always @(negedge clk) begin
    cyc_no++;
    if (bus.awvalid && bus.awready) begin aw_cnt++; aw_cyc = cyc_no; aw_addr_seen = bus.awaddr; end
    if (bus.wvalid && bus.wready) begin w_cnt++; w_cyc = cyc_no; w_data_seen = bus.wdata; end
    if (bus.bvalid && bus.bready) b_cnt++;
    if (bus.arvalid && bus.arready) begin ar_cnt++; ar_addr_seen = bus.araddr; end
    if (bus.ss_tvalid && bus.ss_tready) begin
      beat_data.push_back(bus.ss_tdata);
      beat_last.push_back(bus.ss_tlast);
    end
    if (bus.wbs_ack_o) ack_cnt++;
    if (bus.awvalid || bus.wvalid || bus.bready || bus.arvalid || bus.rready ||
        bus.ss_tvalid || bus.sm_tready) act_cnt++;
  end

  task automatic wb_xfer(input logic [31:0] adr, input logic [31:0] dat, input logic we,
                         input int maxc, output logic acked, output logic [31:0] rdat,
                         output int lat);
    @(posedge clk); #1;
    bus.wbs_adr_i = adr; bus.wbs_dat_i = dat; bus.wbs_we_i = we; bus.wbs_sel_i = 4'hF;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    acked = 1'b0; rdat = '0; lat = 0;
    while (!acked && lat < maxc) begin
      @(posedge clk); #1;
      lat++;
      if (bus.wbs_ack_o) begin acked = 1'b1; rdat = bus.wbs_dat_o; end
    end
    bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic        acked;
  logic [31:0] rdat;
  int          lat, n, aw0, w0, b0, ar0, ack0, act0;

  initial begin
    bus.wbs_stb_i = 0; bus.wbs_cyc_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = '0;
    bus.wbs_adr_i = '0; bus.wbs_dat_i = '0;

    // Reset state
    idle(3);
    check("rst_ctrl", outs(), 32'h0);
    check("rst_dat", bus.wbs_dat_o, 32'h0);
    rst = 1'b0;
    idle(2);

    // 1: LEN write, awready two cycles ahead of wready
    w_delay = 2;
    aw0 = aw_cnt; w0 = w_cnt; b0 = b_cnt; ack0 = ack_cnt;
    wb_xfer(32'h3000_0010, 32'd4, 1'b1, 50, acked, rdat, lat);
    idle(3);
    check("t1_ack", 32'(acked), 32'd1);
    check("t1_ack_cnt", 32'(ack_cnt - ack0), 32'd1);
    check("t1_aw_cnt", 32'(aw_cnt - aw0), 32'd1);
    check("t1_w_cnt", 32'(w_cnt - w0), 32'd1);
    check("t1_b_cnt", 32'(b_cnt - b0), 32'd1);
    check("t1_aw_to_w", 32'(w_cyc - aw_cyc), 32'd2);
    check("t1_awaddr", 32'(aw_addr_seen), 32'h010);
    check("t1_wdata", w_data_seen, 32'd4);
    check("t1_len_cnt", dut.u_len.len_cnt, 32'd4);

    // 2: four stream beats with toggling tready, tlast on the fourth
    w_delay = 0; ss_toggle = 1'b1;
    beat_data.delete(); beat_last.delete();
    for (int i = 1; i <= 4; i++) begin
      wb_xfer(32'h3000_0040, 32'(i), 1'b1, 50, acked, rdat, lat);
      check("t2_ack", 32'(acked), 32'd1);
    end
    idle(2);
    check("t2_beats", 32'(beat_data.size()), 32'd4);
    for (int i = 0; i < beat_data.size(); i++) begin
      check("t2_tdata", beat_data[i], 32'(i + 1));
      check("t2_tlast", 32'(beat_last[i]), (i == 3) ? 32'd1 : 32'd0);
    end
    ss_toggle = 1'b0;

    // 3: AXI-Lite read, rvalid three cycles after rready
    r_delay = 3; rdata_val = 32'h0000_0004; ar0 = ar_cnt;
    wb_xfer(32'h3000_0000, 32'h0, 1'b0, 50, acked, rdat, lat);
    check("t3_ack", 32'(acked), 32'd1);
    check("t3_rdat", rdat, 32'h0000_0004);
    check("t3_ar_cnt", 32'(ar_cnt - ar0), 32'd1);
    check("t3_araddr", 32'(ar_addr_seen), 32'h000);

    // 4: stream read with no data -> timeout error
    wb_xfer(32'h3000_0044, 32'h0, 1'b0, 400, acked, rdat, lat);
    check("t4_ack", 32'(acked), 32'd1);
    check("t4_latency", 32'(lat), 32'd257);
    check("t4_rdat", rdat, 32'hDEAD_BEEF);
    check("t4_timeout_o", 32'(timeout_o), 32'd1);
    check("t4_sm_tready", 32'(bus.sm_tready), 32'd0);
    idle(2);

    // 5: out-of-window write is ignored
    act0 = act_cnt; ack0 = ack_cnt;
    wb_xfer(32'h3100_0000, 32'h55, 1'b1, 300, acked, rdat, lat);
    check("t5_no_ack", 32'(acked), 32'd0);
    check("t5_no_axi", 32'(act_cnt - act0), 32'd0);
    check("t5_ack_cnt", 32'(ack_cnt - ack0), 32'd0);

    // 6: reset while waiting for read data, then a normal read
    r_delay = 1000;
    @(posedge clk); #1;
    bus.wbs_adr_i = 32'h3000_0000; bus.wbs_we_i = 1'b0; bus.wbs_sel_i = 4'hF;
    bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
    n = 0;
    while (!bus.rready && n < 20) begin @(posedge clk); #1; n++; end
    check("t6_in_rd_d", 32'(bus.rready), 32'd1);
    rst = 1'b1; bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
    @(posedge clk); #1;
    check("t6_rst_ctrl", outs(), 32'h0);
    check("t6_rst_dat", bus.wbs_dat_o, 32'h0);
    rst = 1'b0; r_delay = 3; rdata_val = 32'h1234_5678;
    idle(2);
    wb_xfer(32'h3000_0008, 32'h0, 1'b0, 50, acked, rdat, lat);
    check("t6_ack", 32'(acked), 32'd1);
    check("t6_rdat", rdat, 32'h1234_5678);
    check("t6_araddr", 32'(ar_addr_seen), 32'h008);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
